// File: rtl/jtkiwi_shr_arb.sv
// Round-robin arbiter that shares one single-port work RAM between the main CPU and the sub/sound CPU.
// Each access is an ACCESS cycle followed by LAT wait cycles. A grant can chain straight out of the ok cycle.
module jtkiwi_shr_arb #(
  parameter int AW  = 13,
  parameter int DW  = 8,
  parameter int LAT = 1     // RAM read latency, legal range 1..3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m_cs,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_din,
  output logic [DW-1:0] m_dout,
  output logic          m_ok,
  input  logic          s_cs,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          s_ok,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  localparam int CW = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_e;
  typedef enum logic {P_MAIN = 1'b0, P_SUB = 1'b1} port_e;

  state_e        state_q, state_d;
  port_e         cur_q, cur_d, last_q, last_d, grant;
  logic          cur_we_q, cur_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_done_q, m_done_d, s_done_q, s_done_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [DW-1:0] m_dout_q, m_dout_d, s_dout_q, s_dout_d;
  logic          finish, m_pend, s_pend, grant_en;

  // State register. A reset aborts any access in flight, so no ok is issued for it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cur_q      <= P_MAIN;
      last_q     <= P_SUB;
      cur_we_q   <= 1'b0;
      cnt_q      <= '0;
      m_done_q   <= 1'b0;
      s_done_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      m_dout_q   <= '0;
      s_dout_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      cur_we_q   <= cur_we_d;
      cnt_q      <= cnt_d;
      m_done_q   <= m_done_d;
      s_done_q   <= s_done_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
      m_dout_q   <= m_dout_d;
      s_dout_q   <= s_dout_d;
    end
  end

  // Arbitration. The port that is finishing this cycle is excluded, so a held cs is not served twice.
  always_comb begin
    finish   = (state_q == S_WAIT) && (cnt_q == '0);
    m_pend   = m_cs && !m_done_q && !(finish && cur_q == P_MAIN);
    s_pend   = s_cs && !s_done_q && !(finish && cur_q == P_SUB);
    grant_en = ((state_q == S_IDLE) || finish) && (m_pend || s_pend);
    if (m_pend && s_pend) grant = (last_q == P_MAIN) ? P_SUB : P_MAIN;
    else                  grant = s_pend ? P_SUB : P_MAIN;
  end

  // Next state and datapath
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block can infer a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    cur_we_d   = cur_we_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    m_dout_d   = m_dout_q;
    s_dout_d   = s_dout_q;

    unique case (state_q)
      S_IDLE:   if (grant_en) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (finish) state_d = grant_en ? S_ACCESS : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_q == S_ACCESS)                cnt_d = CW'(LAT - 1);
    else if (state_q == S_WAIT && !finish)  cnt_d = cnt_q - 1'b1;

    if (finish) begin
      last_d = cur_q;
      if (!cur_we_q) begin
        if (cur_q == P_MAIN) m_dout_d = ram_dout;
        else                 s_dout_d = ram_dout;
      end
    end

    if (grant_en) begin
      cur_d = grant;
      if (grant == P_MAIN) begin
        cur_we_d   = m_we;
        ram_we_d   = m_we;
        ram_addr_d = m_addr;
        ram_din_d  = m_din;
      end else begin
        cur_we_d   = s_we;
        ram_we_d   = s_we;
        ram_addr_d = s_addr;
        ram_din_d  = s_din;
      end
    end

    // done is set by ok while cs is held. Any cycle with cs low clears it.
    m_done_d = m_cs && (m_done_q || m_ok);
    s_done_d = s_cs && (s_done_q || s_ok);
  end

  // Outputs. Read data bypasses the holding register in the ok cycle itself.
  always_comb begin
    m_ok     = finish && (cur_q == P_MAIN);
    s_ok     = finish && (cur_q == P_SUB);
    busy     = (state_q != S_IDLE);
    m_dout   = (m_ok && !cur_we_q) ? ram_dout : m_dout_q;
    s_dout   = (s_ok && !cur_we_q) ? ram_dout : s_dout_q;
    ram_addr = ram_addr_q;
    ram_we   = ram_we_q;
    ram_din  = ram_din_q;
  end

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Directed bench for jtkiwi_shr_arb: one LAT=1 instance and one LAT=3 instance, each with its own RAM model.
module tb_jtkiwi_shr_arb;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn1, rstn3;
  logic          m1_cs, m1_we, s1_cs, s1_we, m1_ok, s1_ok, rwe1, busy1;
  logic [AW-1:0] m1_addr, s1_addr, ra1;
  logic [DW-1:0] m1_din, s1_din, m1_dout, s1_dout, rdi1, rdo1;
  logic          m3_cs, m3_we, s3_cs, s3_we, m3_ok, s3_ok, rwe3, busy3;
  logic [AW-1:0] m3_addr, s3_addr, ra3;
  logic [DW-1:0] m3_din, s3_din, m3_dout, s3_dout, rdi3, rdo3;

  jtkiwi_shr_arb #(.AW(AW), .DW(DW), .LAT(1)) dut1 (
    .clk(clk), .rstn(rstn1),
    .m_cs(m1_cs), .m_we(m1_we), .m_addr(m1_addr), .m_din(m1_din), .m_dout(m1_dout), .m_ok(m1_ok),
    .s_cs(s1_cs), .s_we(s1_we), .s_addr(s1_addr), .s_din(s1_din), .s_dout(s1_dout), .s_ok(s1_ok),
    .ram_addr(ra1), .ram_we(rwe1), .ram_din(rdi1), .ram_dout(rdo1), .busy(busy1)
  );

  jtkiwi_shr_arb #(.AW(AW), .DW(DW), .LAT(3)) dut3 (
    .clk(clk), .rstn(rstn3),
    .m_cs(m3_cs), .m_we(m3_we), .m_addr(m3_addr), .m_din(m3_din), .m_dout(m3_dout), .m_ok(m3_ok),
    .s_cs(s3_cs), .s_we(s3_we), .s_addr(s3_addr), .s_din(s3_din), .s_dout(s3_dout), .s_ok(s3_ok),
    .ram_addr(ra3), .ram_we(rwe3), .ram_din(rdi3), .ram_dout(rdo3), .busy(busy3)
  );

  function automatic logic [7:0] f(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
  endfunction

  // RAM models, filled with f(addr) on the first edge
  logic [7:0] mem1 [8192];
  logic [7:0] mem3 [8192];
  logic [7:0] p0, p1, p2;
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) begin
        mem1[i] <= f(13'(i));
        mem3[i] <= f(13'(i));
      end
      mem1[13'h0123] <= 8'hA5;
      mem_ready <= 1'b1;
    end else begin
      if (rwe1) mem1[ra1] <= rdi1;
      if (rwe3) mem3[ra3] <= rdi3;
      rdo1 <= mem1[ra1];
      p0   <= mem3[ra3];
      p1   <= p0;
      p2   <= p1;
    end
  end
  assign rdo3 = p2;

  // Event counters
  int  we1_n = 0, mok1_n = 0, sok3_n = 0, back2back = 0;
  logic pwe1 = 1'b0, pwe3 = 1'b0;
  always @(posedge clk) begin
    we1_n  <= we1_n + int'(rwe1);
    mok1_n <= mok1_n + int'(m1_ok);
    sok3_n <= sok3_n + int'(s3_ok);
    pwe1   <= rwe1;
    pwe3   <= rwe3;
    if ((rwe1 && pwe1) || (rwe3 && pwe3)) back2back <= back2back + 1;
  end

  int n_cmp = 0, n_fail = 0;
  logic [7:0] shadow3 [8192];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int w0, o0, s0;
    for (int i = 0; i < 8192; i++) shadow3[i] = f(13'(i));
    rstn1 = 1'b0; rstn3 = 1'b0;
    {m1_cs, m1_we, s1_cs, s1_we, m3_cs, m3_we, s3_cs, s3_we} = '0;
    {m1_addr, s1_addr, m3_addr, s3_addr} = '0;
    {m1_din, s1_din, m3_din, s3_din} = '0;
    tick(); tick();

    // Reset state
    check("rst_ram_addr", ra1, 0);
    check("rst_ram_we", rwe1, 0);
    check("rst_ram_din", rdi1, 0);
    check("rst_busy", busy1, 0);
    check("rst_m_ok", m1_ok, 0);
    check("rst_s_ok", s1_ok, 0);
    check("rst_m_dout", m1_dout, 0);
    check("rst_s_dout", s1_dout, 0);
    rstn1 = 1'b1; rstn3 = 1'b1;
    tick();

    // Main read, LAT=1: pending at N, address at N+1, ok and data at N+2
    m1_cs = 1'b1; m1_we = 1'b0; m1_addr = 13'h0123;
    check("t1_idle_busy", busy1, 0);
    tick();
    check("t1_ram_addr", ra1, 13'h0123);
    check("t1_ram_we", rwe1, 0);
    check("t1_busy", busy1, 1);
    check("t1_ok_early", m1_ok, 0);
    tick();
    check("t1_m_ok", m1_ok, 1);
    check("t1_m_dout", m1_dout, 8'hA5);
    check("t1_s_ok_quiet", s1_ok, 0);
    m1_cs = 1'b0;
    tick();
    check("t1_ok_clear", m1_ok, 0);
    check("t1_dout_hold", m1_dout, 8'hA5);
    check("t1_busy_clear", busy1, 0);

    // Reset pulse, then simultaneous requests: main write wins, sub read follows
    rstn1 = 1'b0;
    #1;
    check("t2_rst_dout", m1_dout, 0);
    tick();
    rstn1 = 1'b1;
    m1_cs = 1'b1; m1_we = 1'b1; m1_addr = 13'h1FFF; m1_din = 8'h5A;
    s1_cs = 1'b1; s1_we = 1'b0; s1_addr = 13'h1FFF;
    w0 = we1_n;
    tick();
    check("t2_main_addr", ra1, 13'h1FFF);
    check("t2_main_we", rwe1, 1);
    check("t2_main_din", rdi1, 8'h5A);
    tick();
    check("t2_m_ok", m1_ok, 1);
    check("t2_we_dropped", rwe1, 0);
    check("t2_write_keeps_dout", m1_dout, 0);
    m1_cs = 1'b0;
    tick();
    check("t2_sub_addr", ra1, 13'h1FFF);
    check("t2_sub_we", rwe1, 0);
    tick();
    check("t2_s_ok", s1_ok, 1);
    check("t2_s_dout", s1_dout, 8'h5A);
    check("t2_we_pulses", we1_n - w0, 1);
    s1_cs = 1'b0;
    tick();

    // Tie after sub was served last: main first
    m1_cs = 1'b1; m1_we = 1'b0; m1_addr = 13'h0010;
    s1_cs = 1'b1; s1_we = 1'b0; s1_addr = 13'h0020;
    tick();
    check("t2b_main_first", ra1, 13'h0010);
    tick(); m1_cs = 1'b0;
    tick(); tick();
    check("t2b_s_ok", s1_ok, 1);
    s1_cs = 1'b0;
    tick();
    // Main alone, then a tie: sub first
    m1_cs = 1'b1; m1_addr = 13'h0030;
    tick(); tick();
    check("t2c_m_ok", m1_ok, 1);
    check("t2c_m_dout", m1_dout, f(13'h0030));
    m1_cs = 1'b0;
    tick();
    m1_cs = 1'b1; m1_addr = 13'h0010;
    s1_cs = 1'b1; s1_addr = 13'h0020;
    tick();
    check("t2c_sub_first", ra1, 13'h0020);
    tick();
    check("t2c_s_ok", s1_ok, 1);
    check("t2c_s_dout", s1_dout, f(13'h0020));
    s1_cs = 1'b0;
    tick();
    check("t2c_main_next", ra1, 13'h0010);
    tick();
    check("t2c_m_ok2", m1_ok, 1);
    check("t2c_m_dout2", m1_dout, f(13'h0010));
    m1_cs = 1'b0;
    tick();

    // cs held ten cycles past ok: served once. A one-cycle drop re-arms it.
    w0 = we1_n; o0 = mok1_n;
    m1_cs = 1'b1; m1_we = 1'b1; m1_addr = 13'h0040; m1_din = 8'h77;
    repeat (12) tick();
    check("t3_one_we", we1_n - w0, 1);
    check("t3_one_ok", mok1_n - o0, 1);
    m1_cs = 1'b0;
    tick();
    m1_cs = 1'b1; m1_din = 8'h78;
    tick(); tick();
    check("t3_second_ok", m1_ok, 1);
    m1_cs = 1'b0;
    tick();
    check("t3_two_we", we1_n - w0, 2);
    check("t3_two_ok", mok1_n - o0, 2);
    check("t3_ram_written", mem1[13'h0040], 8'h78);

    // Abandoned write: cs dropped the cycle after the grant
    m1_cs = 1'b1; m1_we = 1'b1; m1_addr = 13'h0100; m1_din = 8'hC3;
    tick();
    m1_cs = 1'b0;
    check("t6_we", rwe1, 1);
    tick();
    check("t6_m_ok", m1_ok, 1);
    tick();
    s1_cs = 1'b1; s1_we = 1'b0; s1_addr = 13'h0100;
    tick(); tick();
    check("t6_s_ok", s1_ok, 1);
    check("t6_s_dout", s1_dout, 8'hC3);
    s1_cs = 1'b0;
    tick();

    // LAT=3, idle arbiter: ok at N+4
    m3_cs = 1'b1; m3_we = 1'b0; m3_addr = 13'h0ABC;
    tick();
    check("l3_ram_addr", ra3, 13'h0ABC);
    tick();
    check("l3_ok_n2", m3_ok, 0);
    tick();
    check("l3_ok_n3", m3_ok, 0);
    tick();
    check("l3_ok_n4", m3_ok, 1);
    check("l3_dout", m3_dout, f(13'h0ABC));
    m3_cs = 1'b0;
    tick();

    // Reset in the middle of a sub read's wait phase
    s3_cs = 1'b1; s3_we = 1'b0; s3_addr = 13'h0555;
    tick(); tick();
    check("r_busy_before", busy3, 1);
    s0 = sok3_n;
    rstn3 = 1'b0;
    #1;
    check("r_ram_addr", ra3, 0);
    check("r_ram_we", rwe3, 0);
    check("r_busy", busy3, 0);
    check("r_s_ok", s3_ok, 0);
    check("r_m_dout", m3_dout, 0);
    tick(); tick();
    check("r_no_ok", sok3_n - s0, 0);
    rstn3 = 1'b1;
    tick();
    check("r_reserve_addr", ra3, 13'h0555);
    tick(); tick(); tick();
    check("r_reserve_ok", s3_ok, 1);
    check("r_reserve_dout", s3_dout, f(13'h0555));
    s3_cs = 1'b0;
    tick();

    // Random sweep, LAT=3: main uses the low half, sub the high half
    fork
      begin : sweep_m
        logic [12:0] a;
        logic        w;
        logic [7:0]  d;
        int          t;
        bit          got;
        for (int i = 0; i < 50; i++) begin
          a = {1'b0, 12'($urandom)}; w = 1'($urandom); d = 8'($urandom);
          m3_cs = 1'b1; m3_we = w; m3_addr = a; m3_din = d;
          t = 0; got = 1'b0;
          while (!got && t < 12) begin
            tick(); t++;
            if (m3_ok) got = 1'b1;
          end
          check("sw_m_ok", got, 1);
          check("sw_m_wait", t <= 8, 1);
          if (got && !w) check("sw_m_data", m3_dout, shadow3[a]);
          if (got && w) shadow3[a] = d;
          m3_cs = 1'b0;
          repeat (1 + $urandom_range(2)) tick();
        end
      end
      begin : sweep_s
        logic [12:0] a;
        logic        w;
        logic [7:0]  d;
        int          t;
        bit          got;
        for (int i = 0; i < 50; i++) begin
          a = {1'b1, 12'($urandom)}; w = 1'($urandom); d = 8'($urandom);
          s3_cs = 1'b1; s3_we = w; s3_addr = a; s3_din = d;
          t = 0; got = 1'b0;
          while (!got && t < 12) begin
            tick(); t++;
            if (s3_ok) got = 1'b1;
          end
          check("sw_s_ok", got, 1);
          check("sw_s_wait", t <= 8, 1);
          if (got && !w) check("sw_s_data", s3_dout, shadow3[a]);
          if (got && w) shadow3[a] = d;
          s3_cs = 1'b0;
          repeat (1 + $urandom_range(2)) tick();
        end
      end
    join
    tick();

    check("we_never_back_to_back", back2back, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
